// File: rtl/rx_byte_tracker_pkg.sv
// Shared types and constants for the RX byte tracker.
package rx_byte_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam int CRC_BYTES = 2;

  function automatic int max_pkt(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/rx_byte_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module rx_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rx_byte_tracker.sv
// Counts RX bytes between sop and eop and publishes the payload length until acked.
// Define RX_CRC_STRIP_EN to exclude the trailing CRC16 bytes from the length.
module rx_byte_tracker
  import rx_byte_tracker_pkg::*;
#(
  parameter int BITS = 6
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            sop,
  input  logic            byte_valid,
  input  logic            eop,
  input  logic            abort,
  input  logic            length_ack,
  output logic [BITS-1:0] packet_length,
  output logic            empty,
  output logic            length_valid,
  output logic            overflow,
  output logic            busy
);

  localparam int RW      = BITS + 2;
  localparam int MAX_PKT = max_pkt(BITS);
`ifdef RX_CRC_STRIP_EN
  localparam int TRIM    = CRC_BYTES;
`else
  localparam int TRIM    = 0;
`endif
  localparam logic [RW-1:0] RAW_ONE = RW'(1);
  localparam logic [RW-1:0] MAX_W   = RW'(MAX_PKT);
  localparam logic [RW:0]   TRIM_W  = (RW + 1)'(TRIM);

  state_t          state_q;
  logic [BITS-1:0] packet_length_q;
  logic            empty_q;
  logic            length_valid_q;
  logic            overflow_q;
  logic            busy_q;

  logic [RW-1:0] raw;
  logic [RW-1:0] raw_eval;
  logic [RW:0]   diff;
  logic [RW-1:0] payload;
  logic          too_short;
  logic          too_long;
  logic          cnt_clear;
  logic          cnt_inc;

  // sop carries no byte, so a restart never counts the byte_valid of that cycle.
  assign cnt_clear = sop && ((state_q == IDLE) || (state_q == COUNT));
  assign cnt_inc   = (state_q == COUNT) && byte_valid && !sop && !abort;

  rx_sat_counter #(.W(RW)) u_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .count_o (raw)
  );

  // The eop cycle may carry the last byte; judge the packet on the saturated total.
  always_comb begin
    raw_eval = raw;
    if (byte_valid && (raw != '1)) begin
      raw_eval = raw + RAW_ONE;
    end
  end

  // One extra bit turns "raw < TRIM" into a borrow check.
  assign diff      = {1'b0, raw_eval} - TRIM_W;
  assign too_short = diff[RW];
  assign payload   = diff[RW-1:0];
  assign too_long  = payload > MAX_W;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      packet_length_q <= '0;
      empty_q         <= 1'b0;
      length_valid_q  <= 1'b0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sop) begin
            state_q <= COUNT;
            busy_q  <= 1'b1;
          end
        end
        COUNT: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (sop) begin
            state_q <= COUNT;
          end else if (eop) begin
            busy_q <= 1'b0;
            if (too_short || too_long) begin
              state_q    <= ERR;
              overflow_q <= 1'b1;
            end else begin
              state_q         <= DONE;
              packet_length_q <= payload[BITS-1:0];
              empty_q         <= (payload == '0);
              length_valid_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (length_ack) begin
            state_q        <= IDLE;
            length_valid_q <= 1'b0;
          end
        end
        ERR: begin
          state_q    <= IDLE;
          overflow_q <= 1'b0;
        end
        default: begin
          state_q        <= IDLE;
          length_valid_q <= 1'b0;
          overflow_q     <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign packet_length = packet_length_q;
  assign empty         = empty_q;
  assign length_valid  = length_valid_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rx_byte_tracker.sv
// Directed bench for rx_byte_tracker: packet table plus restart/ignore/abort/reset sequences.
module tb_rx_byte_tracker;

  localparam int BITS = 6;

  logic            clk;
  logic            n_rst;
  logic            sop;
  logic            byte_valid;
  logic            eop;
  logic            abort;
  logic            length_ack;
  logic [BITS-1:0] packet_length;
  logic            empty;
  logic            length_valid;
  logic            overflow;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  rx_byte_tracker #(.BITS(BITS)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sop           (sop),
    .byte_valid    (byte_valid),
    .eop           (eop),
    .abort         (abort),
    .length_ack    (length_ack),
    .packet_length (packet_length),
    .empty         (empty),
    .length_valid  (length_valid),
    .overflow      (overflow),
    .busy          (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nbytes;
    bit eop_last;
    bit exp_valid;
    int exp_len;
    bit exp_empty;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int n, input bit last, input bit v,
                         input int len, input bit e, input bit o);
    vecs[i].nbytes    = n;
    vecs[i].eop_last  = last;
    vecs[i].exp_valid = v;
    vecs[i].exp_len   = len;
    vecs[i].exp_empty = e;
    vecs[i].exp_ovf   = o;
  endtask

  // Driver: sop, n bytes, eop (with the last byte or alone); returns one negedge after the eop edge.
  task automatic send_packet(input int n, input bit last);
    @(negedge clk);
    sop = 1'b1;
    @(negedge clk);
    sop = 1'b0;
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      eop        = last && (i == n - 1);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!last || n == 0) begin
      eop = 1'b1;
      @(negedge clk);
    end
    eop = 1'b0;
  endtask

  task automatic do_ack(input string name);
    length_ack = 1'b1;
    @(negedge clk);
    length_ack = 1'b0;
    check({name, "_lv_after_ack"}, length_valid, 0);
  endtask

  initial begin
    n_rst      = 1'b0;
    sop        = 1'b0;
    byte_valid = 1'b0;
    eop        = 1'b0;
    abort      = 1'b0;
    length_ack = 1'b0;

`ifdef RX_CRC_STRIP_EN
    set_vec(0,  10, 0, 1,  8, 0, 0);
    set_vec(1,  64, 1, 1, 62, 0, 0);
    set_vec(2,  65, 0, 1, 63, 0, 0);
    set_vec(3,   0, 0, 0,  0, 0, 1);
    set_vec(4,   1, 1, 0,  0, 0, 1);
    set_vec(5,   2, 0, 1,  0, 1, 0);
    set_vec(6,  63, 0, 1, 61, 0, 0);
    set_vec(7,  66, 0, 1,  0, 0, 0);
    set_vec(8,  67, 0, 0,  0, 0, 1);
    set_vec(9, 300, 0, 0,  0, 0, 1);
    set_vec(10, 12, 0, 1, 10, 0, 0);
`else
    set_vec(0,  10, 0, 1, 10, 0, 0);
    set_vec(1,  64, 1, 1,  0, 0, 0);
    set_vec(2,  65, 0, 0,  0, 0, 1);
    set_vec(3,   0, 0, 1,  0, 1, 0);
    set_vec(4,   1, 1, 1,  1, 0, 0);
    set_vec(5,   2, 0, 1,  2, 0, 0);
    set_vec(6,  63, 0, 1, 63, 0, 0);
    set_vec(7,  66, 0, 0,  0, 0, 1);
    set_vec(8,  67, 0, 0,  0, 0, 1);
    set_vec(9, 300, 0, 0,  0, 0, 1);
    set_vec(10, 12, 0, 1, 12, 0, 0);
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_lv",   length_valid,  0);
    check("rst_ovf",  overflow,      0);
    check("rst_busy", busy,          0);
    check("rst_len",  packet_length, 0);
    check("rst_emp",  empty,         0);
    n_rst = 1'b1;
    @(negedge clk);

    // IDLE ignores bytes/eop without sop
    byte_valid = 1'b1;
    eop        = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    eop        = 1'b0;
    @(negedge clk);
    check("idle_ign_lv",   length_valid, 0);
    check("idle_ign_busy", busy,         0);
    check("idle_ign_ovf",  overflow,     0);

    // Table of packets
    for (int v = 0; v < 11; v++) begin
      send_packet(vecs[v].nbytes, vecs[v].eop_last);
      check($sformatf("v%0d_ovf", v),  overflow,     int'(vecs[v].exp_ovf));
      check($sformatf("v%0d_lv", v),   length_valid, int'(vecs[v].exp_valid));
      check($sformatf("v%0d_busy", v), busy,         0);
      if (vecs[v].exp_valid) begin
        check($sformatf("v%0d_len", v), packet_length, vecs[v].exp_len);
        check($sformatf("v%0d_emp", v), empty,         int'(vecs[v].exp_empty));
      end
      @(negedge clk);
      check($sformatf("v%0d_ovf_drop", v), overflow,     0);
      check($sformatf("v%0d_lv_hold", v),  length_valid, int'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) do_ack($sformatf("v%0d", v));
    end

    // Busy during COUNT, then sop restarts the count
    @(negedge clk);
    sop = 1'b1;
    @(negedge clk);
    sop = 1'b0;
    check("cnt_busy", busy, 1);
    byte_valid = 1'b1;
    repeat (20) @(negedge clk);
    byte_valid = 1'b0;
    send_packet(5, 1'b0);
    check("restart_lv", length_valid, 1);
`ifdef RX_CRC_STRIP_EN
    check("restart_len", packet_length, 3);
`else
    check("restart_len", packet_length, 5);
`endif
    do_ack("restart");

    // sop in DONE is ignored; length stays until ack
    send_packet(12, 1'b0);
    send_packet(30, 1'b0);
    check("done_ign_lv",   length_valid, 1);
    check("done_ign_busy", busy,         0);
`ifdef RX_CRC_STRIP_EN
    check("done_ign_len", packet_length, 10);
`else
    check("done_ign_len", packet_length, 12);
`endif
    do_ack("done_ign");

    // Abort beats eop in the same cycle
    @(negedge clk);
    sop = 1'b1;
    @(negedge clk);
    sop        = 1'b0;
    byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    abort      = 1'b1;
    eop        = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    eop   = 1'b0;
    check("abort_busy", busy,         0);
    check("abort_lv",   length_valid, 0);
    check("abort_ovf",  overflow,     0);
    @(negedge clk);
    check("abort_ovf2", overflow,     0);
    check("abort_lv2",  length_valid, 0);

    // Async reset while DONE clears outputs immediately
    send_packet(10, 1'b0);
    check("pre_rst_lv", length_valid, 1);
    #2 n_rst = 1'b0;
    #1;
    check("arst_lv",  length_valid,  0);
    check("arst_len", packet_length, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Async reset mid-packet
    @(negedge clk);
    sop = 1'b1;
    @(negedge clk);
    sop        = 1'b0;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_busy_pre", busy, 1);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_busy", busy,         0);
    check("mid_rst_lv",   length_valid, 0);
    check("mid_rst_ovf",  overflow,     0);
    byte_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    eop   = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    @(negedge clk);
    check("post_rst_lv",  length_valid, 0);
    check("post_rst_ovf", overflow,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
